// File: rtl/lab2_pkg.sv
// Shared types and constants for the Lab 2 dual seven-segment display scan.
package lab2_pkg;

  typedef enum logic [1:0] {SHOW0, BLANK0, SHOW1, BLANK1} scan_state_t;

  localparam int unsigned HEX_W     = 4;
  localparam logic [1:0]  ANODE_OFF = 2'b11;
  localparam logic [1:0]  ANODE_D0  = 2'b10;
  localparam logic [1:0]  ANODE_D1  = 2'b01;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/display_mux_ctrl_dwell_counter.sv
// Terminal-count dwell counter: counts 0..load-1 while enabled, flags the last cycle.
module dwell_counter #(
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned LOAD_W = CNT_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [LOAD_W-1:0] load,
  output logic              done_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A load of 0 or 1 means a single-cycle (or skipped) dwell, so done is immediate.
  always_comb begin
    done_c = en && ((load <= LOAD_W'(1)) || (LOAD_W'(cnt_q) == (load - LOAD_W'(1))));
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_mux_ctrl.sv
// Time-multiplexes one hex decoder across two digits with blanking gaps
// between digits; all outputs are registered.
module display_mux_ctrl
  import lab2_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 20000,
  parameter int unsigned BLANK_CYCLES = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [HEX_W-1:0] switch1,
  input  logic [HEX_W-1:0] switch2,
  output logic [HEX_W-1:0] hex_sel,
  output logic [1:0]       anode,
  output logic             digit_sel
);

  localparam int unsigned CNT_W      = $clog2(max3(REFRESH_DIV, BLANK_CYCLES, 2));
  localparam int unsigned LOAD_W     = CNT_W + 1;
  localparam bit          SKIP_BLANK = (BLANK_CYCLES == 0);

  scan_state_t       state_q, state_d;
  logic [HEX_W-1:0]  hex_sel_q, hex_sel_d;
  logic [1:0]        anode_q, anode_d;
  logic              digit_sel_q, digit_sel_d;
  logic [LOAD_W-1:0] load_c;
  logic              done_c;

  always_comb begin
    load_c = ((state_q == SHOW0) || (state_q == SHOW1)) ? LOAD_W'(REFRESH_DIV)
                                                         : LOAD_W'(BLANK_CYCLES);
  end

  dwell_counter #(
    .CNT_W  (CNT_W),
    .LOAD_W (LOAD_W)
  ) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .clear  (done_c),
    .en     (en),
    .load   (load_c),
    .done_c (done_c)
  );

  // Next state, with output values chosen by the state being entered.
  always_comb begin
    state_d     = state_q;
    hex_sel_d   = hex_sel_q;
    anode_d     = anode_q;
    digit_sel_d = digit_sel_q;
    if (done_c) begin
      unique case (state_q)
        SHOW0:   state_d = SKIP_BLANK ? SHOW1 : BLANK0;
        BLANK0:  state_d = SHOW1;
        SHOW1:   state_d = SKIP_BLANK ? SHOW0 : BLANK1;
        BLANK1:  state_d = SHOW0;
        default: state_d = BLANK1;
      endcase
      unique case (state_d)
        SHOW0: begin
          hex_sel_d   = switch1;
          digit_sel_d = 1'b0;
          anode_d     = ANODE_D0;
        end
        SHOW1: begin
          hex_sel_d   = switch2;
          digit_sel_d = 1'b1;
          anode_d     = ANODE_D1;
        end
        default: anode_d = ANODE_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BLANK1;
      hex_sel_q   <= '0;
      anode_q     <= ANODE_OFF;
      digit_sel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hex_sel_q   <= hex_sel_d;
      anode_q     <= anode_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign hex_sel   = hex_sel_q;
  assign anode     = anode_q;
  assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Bench for display_mux_ctrl: one instance with blanking, one without, same stimulus.
module tb_display_mux_ctrl;

  localparam int R  = 4;
  localparam int B0 = 2;
  localparam int B1 = 0;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] sw1, sw2;
  logic [3:0] hex_a, hex_b;
  logic [1:0] an_a, an_b;
  logic       dig_a, dig_b;

  int n_checks;
  int n_fail;

  int         k[2];
  logic [3:0] m_hex[2];
  logic       m_dig[2];

  typedef struct {
    logic [1:0] anode;
    logic [3:0] hex;
  } vec_t;
  vec_t tbl[12];

  display_mux_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(B0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .switch1(sw1), .switch2(sw2),
    .hex_sel(hex_a), .anode(an_a), .digit_sel(dig_a));

  display_mux_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(B1)) dut_b (
    .clk(clk), .reset(reset), .en(en), .switch1(sw1), .switch2(sw2),
    .hex_sel(hex_b), .anode(an_b), .digit_sel(dig_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int blank_of(input int i);
    return (i == 0) ? B0 : B1;
  endfunction

  // Position within the scan period: SHOW0 at 0, BLANK0, SHOW1 at R+B, BLANK1; -1 = post-reset idle.
  function automatic int pos_of(input int i, input int kk);
    int b;
    int p;
    b = blank_of(i);
    p = 2 * (R + b);
    if (b > 0) return (2 * R + b + kk) % p;
    if (kk == 0) return -1;
    return (kk - 1) % p;
  endfunction

  function automatic logic [1:0] exp_anode(input int i);
    int p;
    int b;
    b = blank_of(i);
    p = pos_of(i, k[i]);
    if (p < 0) return 2'b11;
    if (p < R) return 2'b10;
    if (p < R + b) return 2'b11;
    if (p < 2 * R + b) return 2'b01;
    return 2'b11;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      k[i] = 0;
      m_hex[i] = 4'h0;
      m_dig[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int p;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        k[i] = 0;
        m_hex[i] = 4'h0;
        m_dig[i] = 1'b0;
      end else if (en) begin
        k[i] = k[i] + 1;
        p = pos_of(i, k[i]);
        if (p == 0) begin
          m_hex[i] = sw1;
          m_dig[i] = 1'b0;
        end else if (p == R + blank_of(i)) begin
          m_hex[i] = sw2;
          m_dig[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check("a_anode", 8'(an_a), 8'(exp_anode(0)));
    check("a_hex", 8'(hex_a), 8'(m_hex[0]));
    check("a_digit", 8'(dig_a), 8'(m_dig[0]));
    check("b_anode", 8'(an_b), 8'(exp_anode(1)));
    check("b_hex", 8'(hex_b), 8'(m_hex[1]));
    check("b_digit", 8'(dig_b), 8'(m_dig[1]));
    check("a_anode_not_00", 8'(an_a != 2'b00), 8'd1);
    check("b_anode_not_00", 8'(an_b != 2'b00), 8'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    tbl[0]  = '{2'b10, 4'hA};
    tbl[1]  = '{2'b10, 4'hA};
    tbl[2]  = '{2'b10, 4'hA};
    tbl[3]  = '{2'b11, 4'hA};
    tbl[4]  = '{2'b11, 4'hA};
    tbl[5]  = '{2'b01, 4'h5};
    tbl[6]  = '{2'b01, 4'h5};
    tbl[7]  = '{2'b01, 4'h5};
    tbl[8]  = '{2'b01, 4'h5};
    tbl[9]  = '{2'b11, 4'h5};
    tbl[10] = '{2'b11, 4'h5};
    tbl[11] = '{2'b10, 4'hA};

    reset = 1'b1;
    en    = 1'b1;
    sw1   = 4'hA;
    sw2   = 4'h5;

    // Reset held for 3 cycles, then released; SHOW0 two edges later.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_anode", 8'(an_a), 8'h3);
      check("rst_hex", 8'(hex_a), 8'h0);
    end
    reset = 1'b0;
    tick();
    check("rel1_anode", 8'(an_a), 8'h3);
    tick();
    check("rel2_anode", 8'(an_a), 8'h2);
    check("rel2_hex", 8'(hex_a), 8'hA);

    // Steady scan, one full 12-cycle period.
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("tbl%0d_anode", i), 8'(an_a), 8'(tbl[i].anode));
      check($sformatf("tbl%0d_hex", i), 8'(hex_a), 8'(tbl[i].hex));
    end

    // switch1 changes in the second SHOW0 cycle; visible only at the next SHOW0.
    tick();
    sw1 = 4'h3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midshow_hold", 8'(hex_a), 8'hA);
    end
    for (int i = 0; i < 8; i++) tick();
    check("midshow_new_anode", 8'(an_a), 8'h2);
    check("midshow_new_hex", 8'(hex_a), 8'h3);

    // Freeze during the third SHOW1 cycle.
    for (int i = 0; i < 8; i++) tick();
    check("frz_pre_anode", 8'(an_a), 8'h1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("frz_anode", 8'(an_a), 8'h1);
      check("frz_hex", 8'(hex_a), 8'h5);
    end
    en = 1'b1;
    tick();
    check("resume1_anode", 8'(an_a), 8'h1);
    tick();
    check("resume2_anode", 8'(an_a), 8'h3);

    // Advance into SHOW1 and pulse reset between edges.
    for (int i = 0; i < 8; i++) tick();
    check("pre_async_anode", 8'(an_a), 8'h1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_a_anode", 8'(an_a), 8'h3);
    check("async_b_anode", 8'(an_b), 8'h3);
    check("async_hex", 8'(hex_a), 8'h0);
    tick();
    tick();
    reset = 1'b0;

    // Recovery of the blanked instance and 3 periods of the unblanked one.
    for (int i = 0; i < 24; i++) begin
      tick();
      check("noblank_anode", 8'(an_b), ((i / 4) % 2 == 0) ? 8'h2 : 8'h1);
      if (i == 1) check("recover_anode", 8'(an_a), 8'h2);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 7) != 0);
      sw1 = 4'($urandom_range(0, 15));
      sw2 = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
